lift_call_latch: RTL and testbench
==================================

# lift_call_latch

Floor-call front end for the five-floor lift controller `lift5`. Captures raw hall/car button presses, holds each as a pending request until the car reaches that floor, and drives the registered per-floor request lines that feed `lift5`'s `ra..re` inputs. It takes the controller's `floor` output as feedback, runs a door-dwell timer at the serviced floor, and clears the request when the door opens.

## Interface
- `NFLOORS`, 5, number of floors and width of `btn` and `req`
- `FLOOR_W`, 3, width of `floor`
- `DWELL`, 3, door-open duration in clock cycles (≥1)
- `clk`  input  1  system clock, rising-edge active
- `rst`  input  1  asynchronous, active-low reset
- `btn`  input  NFLOORS  raw button levels; bit i = floor i (bit0 = A … bit4 = E)
- `floor`  input  FLOOR_W  current floor reported by `lift5`
- `req`  output  NFLOORS  pending requests; bit0→`ra` … bit4→`re`; registered
- `door_open`  output  1  high while dwelling at a serviced floor; registered
- `pending`  output  3  popcount of `req`; combinational from `req`

## Operation
- Edge detect: a request sets on a 0→1 transition of the synchronised button, never on level. A button held high latches once.
- Set: `req[i]` goes to 1 on a detected edge and stays set until serviced. A repeat press on an already-set bit has no effect.
- FSM states: MOVING (reset state) and DOOR.
- MOVING→DOOR: `floor` < NFLOORS and `req[floor]`=1. On that edge: clear `req[floor]`, set `door_open`=1, load timer = DWELL.
- DOOR: timer decrements each cycle. When the timer is 1: go to MOVING, set `door_open`=0.
- DOOR ignores `floor` changes.
- In DOOR, edges for the floor latched at DOOR entry are discarded because the car is already there. Edges for other floors latch normally.
- Simultaneous set and clear of the same bit in the MOVING→DOOR cycle: clear wins, and the bit ends at 0.
- `floor` ≥ NFLOORS: no service and no clear. The FSM stays in MOVING.
- `pending` = number of 1s in `req`, range 0..5.

## Timing
- Reset (`rst`=0, asynchronous): `req`=0, `door_open`=0, `pending`=0, state MOVING, timer 0, all synchroniser and edge flops 0. Deassertion takes effect at the next rising edge.
- Set latency (with `CALL_SYNC_EN`): `btn[i]` first sampled high at edge k → `req[i]`=1 after edge k+2.
- Clear latency: `req[floor]` set with `floor` matching is seen at edge k → `req[floor]`=0 and `door_open`=1 after edge k.
- `door_open` stays high for exactly DWELL cycles and then drops.
- A new service cannot start on the edge where `door_open` falls. The earliest next DOOR entry is the following edge.
- Reset mid-DOOR: `door_open` drops immediately, and all pending requests are lost.

## Configuration
- `LIFT_CALL_SYNC_EN` defined: `btn` passes through a 2-flop synchroniser before edge detection, giving a set latency of edge k+2.
- `LIFT_CALL_SYNC_EN` undefined: no synchroniser. `btn` must be synchronous to `clk`. Edge detection runs directly on `btn`, and `req[i]` is set after edge k.
- All other behaviour is identical in both builds.

## Test plan
- Reset then idle: hold `rst`=0 for 2 cycles, `btn`=0 → `req`=00000, `door_open`=0, `pending`=0. Assert `rst` low mid-DOOR → `door_open`=0 with no clock edge.
- Single call, sync build: `btn`=00100 for 1 cycle with `floor`=0 → `req`=00100 after edge k+2 and `pending`=1. Then `floor`=2 → `req`=00000 and `door_open` high for exactly 3 cycles.
- Held button: `btn[3]` high for 10 cycles, `floor`=0 → exactly one set of `req[3]`. No re-set after it is cleared at `floor`=3 while `btn[3]` stays high.
- Multi-call: pulse `btn`=10011 → `pending`=3. Step `floor` 0,1,…,4 with a DWELL wait at each → bits clear in the order 0, 1, 4 and `pending` reaches 0.
- Press during DOOR: dwelling at floor 1, pulse `btn`=00011 → `req`=00001, so floor 1 is discarded and floor 0 is latched.
- Out-of-range floor: `req`=11111, `floor`=6 → no clear, `door_open` stays 0. Non-sync build: a `btn` edge sets `req` after the sampling edge k.

Source files
------------

// File: rtl/lift_call_latch.sv
// lift_call_latch: floor-call front end for the five-floor lift controller.
// Latches button presses as pending per-floor requests, services a request
// when the car reports that floor, and times the door-open dwell.
// Optional feature: define LIFT_CALL_SYNC_EN to put a 2-flop synchroniser on
// the button inputs (set latency becomes two extra edges). Without it the
// buttons are assumed synchronous to clk.
module lift_call_latch #(
  parameter int NFLOORS = 5,
  parameter int FLOOR_W = 3,
  parameter int DWELL   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0] floor,
  output logic [NFLOORS-1:0] req,
  output logic               door_open,
  output logic [2:0]         pending
);

  localparam int TIMER_W = (DWELL < 2) ? 1 : $clog2(DWELL + 1);

  localparam logic [0:0] MOVING = 1'b0;
  localparam logic [0:0] DOOR   = 1'b1;

  logic [NFLOORS-1:0] btnSync;
  logic [NFLOORS-1:0] btnPrev_q;
  logic [NFLOORS-1:0] req_q, req_d;
  logic [0:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [FLOOR_W-1:0] doorFloor_q, doorFloor_d;
  logic               doorOpen_q, doorOpen_d;

  logic [NFLOORS-1:0] floorMatch;
  logic [NFLOORS-1:0] doorMask;
  logic [NFLOORS-1:0] newEdges;
  logic [NFLOORS-1:0] clearMask;
  logic               serviceHit;
  logic [2:0]         pendingCount;

`ifdef LIFT_CALL_SYNC_EN
  logic [NFLOORS-1:0] sync1_q, sync2_q;

  // Two-stage synchroniser for asynchronous button levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  assign btnSync = sync2_q;
`else
  assign btnSync = btn;
`endif

  // One-hot decode of the reported floor and of the floor held at door entry;
  // a floor code outside 0..NFLOORS-1 decodes to all zeros and so never services
  always_comb begin
    floorMatch = '0;
    doorMask   = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (floor == FLOOR_W'(i)) floorMatch[i] = 1'b1;
      if (doorFloor_q == FLOOR_W'(i)) doorMask[i] = 1'b1;
    end
  end

  assign serviceHit = |(floorMatch & req_q);

  // Next-state logic: rising-edge request capture, service decision, dwell timer
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    doorFloor_d = doorFloor_q;
    doorOpen_d  = doorOpen_q;
    newEdges    = btnSync & ~btnPrev_q;
    clearMask   = '0;
    case (state_q)
      MOVING: begin
        if (serviceHit) begin
          state_d     = DOOR;
          clearMask   = floorMatch;
          doorOpen_d  = 1'b1;
          timer_d     = TIMER_W'(DWELL);
          doorFloor_d = floor;
        end
      end
      DOOR: begin
        newEdges = newEdges & ~doorMask;
        if (timer_q == TIMER_W'(1)) begin
          state_d    = MOVING;
          doorOpen_d = 1'b0;
          timer_d    = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = MOVING;
      end
    endcase
    req_d = (req_q | newEdges) & ~clearMask;
  end

  // State, request and door registers; reset drops everything immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnPrev_q   <= '0;
      req_q       <= '0;
      state_q     <= MOVING;
      timer_q     <= '0;
      doorFloor_q <= '0;
      doorOpen_q  <= 1'b0;
    end else begin
      btnPrev_q   <= btnSync;
      req_q       <= req_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      doorFloor_q <= doorFloor_d;
      doorOpen_q  <= doorOpen_d;
    end
  end

  // Population count of the pending request lines
  always_comb begin
    pendingCount = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      pendingCount = pendingCount + 3'(req_q[i]);
    end
  end

  assign req       = req_q;
  assign door_open = doorOpen_q;
  assign pending   = pendingCount;

endmodule

// File: tb/tb_lift_call_latch.sv
// Directed self-checking bench for lift_call_latch (DWELL = 3).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_lift_call_latch;

  logic       clk;
  logic       rst;
  logic [4:0] btn;
  logic [2:0] floor;
  logic [4:0] req;
  logic       door_open;
  logic [2:0] pending;

  int checks;
  int errors;

`ifdef LIFT_CALL_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  lift_call_latch #(.NFLOORS(5), .FLOOR_W(3), .DWELL(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .floor     (floor),
    .req       (req),
    .door_open (door_open),
    .pending   (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseBtn(input logic [4:0] pattern);
    btn = pattern;
    @(negedge clk);
    btn = 5'b0;
    stepCycles(SL);
  endtask

  initial begin
    logic [4:0] multiExp [5];
    logic       multiDoor [5];
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    btn    = 5'b0;
    floor  = 3'd0;

    // reset and idle
    stepCycles(2);
    checkOutput("reset_req", req, 5'b00000);
    checkOutput("reset_door", door_open, 1'b0);
    checkOutput("reset_pending", pending, 3'd0);
    rst = 1'b1;
    stepCycles(2);
    checkOutput("idle_req", req, 5'b00000);

    // single call to floor 2
    pulseBtn(5'b00100);
    checkOutput("single_req", req, 5'b00100);
    checkOutput("single_pending", pending, 3'd1);
    floor = 3'd2;
    @(negedge clk);
    checkOutput("single_clear", req, 5'b00000);
    checkOutput("single_door1", door_open, 1'b1);
    @(negedge clk);
    checkOutput("single_door2", door_open, 1'b1);
    @(negedge clk);
    checkOutput("single_door3", door_open, 1'b1);
    @(negedge clk);
    checkOutput("single_door_drop", door_open, 1'b0);
    floor = 3'd0;
    @(negedge clk);

    // held button latches once and does not re-set after service
    btn = 5'b01000;
    stepCycles(1 + SL);
    checkOutput("held_set", req, 5'b01000);
    checkOutput("held_pending", pending, 3'd1);
    stepCycles(5);
    checkOutput("held_still", req, 5'b01000);
    floor = 3'd3;
    @(negedge clk);
    checkOutput("held_clear", req, 5'b00000);
    checkOutput("held_door", door_open, 1'b1);
    stepCycles(3);
    checkOutput("held_door_drop", door_open, 1'b0);
    floor = 3'd0;
    stepCycles(3);
    checkOutput("held_no_reset", req, 5'b00000);
    btn = 5'b0;
    stepCycles(2);

    // multi-call, serviced walking floors 0..4
    floor = 3'd5;
    pulseBtn(5'b10011);
    checkOutput("multi_req", req, 5'b10011);
    checkOutput("multi_pending", pending, 3'd3);
    multiExp[0] = 5'b10010; multiDoor[0] = 1'b1;
    multiExp[1] = 5'b10000; multiDoor[1] = 1'b1;
    multiExp[2] = 5'b10000; multiDoor[2] = 1'b0;
    multiExp[3] = 5'b10000; multiDoor[3] = 1'b0;
    multiExp[4] = 5'b00000; multiDoor[4] = 1'b1;
    for (int f = 0; f < 5; f++) begin
      floor = 3'(f);
      @(negedge clk);
      checkOutput($sformatf("multi_req_f%0d", f), req, multiExp[f]);
      checkOutput($sformatf("multi_door_f%0d", f), door_open, multiDoor[f]);
      stepCycles(3);
    end
    checkOutput("multi_pending_end", pending, 3'd0);
    checkOutput("multi_door_end", door_open, 1'b0);

    // press during DOOR: dwelling floor discarded, other floor latched
    floor = 3'd5;
    pulseBtn(5'b00010);
    floor = 3'd1;
    @(negedge clk);
    checkOutput("dpress_door", door_open, 1'b1);
    pulseBtn(5'b00011);
    checkOutput("dpress_req", req, 5'b00001);
    stepCycles(4);
    checkOutput("dpress_door_drop", door_open, 1'b0);
    floor = 3'd0;
    @(negedge clk);
    checkOutput("dpress_serve0", req, 5'b00000);
    checkOutput("dpress_serve0_door", door_open, 1'b1);
    stepCycles(3);

    // floor change ignored in DOOR; next service waits one edge after drop
    floor = 3'd5;
    pulseBtn(5'b01100);
    floor = 3'd2;
    @(negedge clk);
    checkOutput("back_req_a", req, 5'b01000);
    floor = 3'd3;
    @(negedge clk);
    checkOutput("back_ignore_floor", req, 5'b01000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("back_drop_door", door_open, 1'b0);
    checkOutput("back_drop_req", req, 5'b01000);
    @(negedge clk);
    checkOutput("back_next_door", door_open, 1'b1);
    checkOutput("back_next_req", req, 5'b00000);
    stepCycles(3);

    // out-of-range floor: nothing serviced
    floor = 3'd6;
    pulseBtn(5'b11111);
    checkOutput("oor_req", req, 5'b11111);
    checkOutput("oor_pending", pending, 3'd5);
    stepCycles(2);
    checkOutput("oor_hold_req", req, 5'b11111);
    checkOutput("oor_door", door_open, 1'b0);

    // asynchronous reset mid-DOOR
    floor = 3'd0;
    @(negedge clk);
    checkOutput("rstdoor_pre", door_open, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstdoor_door", door_open, 1'b0);
    checkOutput("rstdoor_req", req, 5'b00000);
    checkOutput("rstdoor_pending", pending, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    stepCycles(2);
    checkOutput("post_reset_req", req, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
